// File: rtl/multicycle_ctrl_fsm.sv
// Purpose: multicycle MIPS-subset control unit; sequences IF/ID/EXE/MEM/WB and drives all datapath strobes.
// Latency: j/jr/jal 2, beq 3, ALU/sw 4, lw 5 cycles per instruction, plus IF_WAIT extra cycles in IF.
// Backpressure: none; instruction memory slowness is absorbed by the fixed IF_WAIT count.
//
// Ports:
//   CLK, RST        rising-edge clock, asynchronous active-high reset
//   op, zero        IR opcode field (valid from ID until the next IRWre), ALU zero flag (valid in EXE_BR)
//   PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegData, DBDataSrc, DataMemRW,
//   ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp   datapath controls, combinational from state + op
//   illegal_op      sticky undefined-opcode flag
// Build option: define ILLEGAL_OP_TRAP_EN to halt on undefined opcodes and raise illegal_op;
// without it undefined opcodes execute as a NOP and illegal_op is tied low.

module multicycle_ctrl_fsm #(
    parameter int          IF_WAIT = 0,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       WrRegData,
    output logic       DBDataSrc,
    output logic       DataMemRW,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp,
    output logic       illegal_op
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] IF_WAIT_C = 2'(IF_WAIT);

    typedef enum logic [3:0] {
        S_IF, S_ID, S_EXE_AL, S_WB_AL, S_EXE_BR, S_EXE_LS, S_MEM, S_WB_LD, S_HALT
    } state_t;

    state_t     state;
    logic [1:0] wait_cnt;

    // Opcode classification
    logic is_halt, is_rtype, is_alu_i, is_alu, is_lw, is_sw, is_ls, is_beq;
    logic is_j, is_jr, is_jal, is_jump;

    always_comb begin
        is_halt  = (op == HALT_OP);
        is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_OR) ||
                   (op == OP_AND) || (op == OP_SLL) || (op == OP_SLT);
        is_alu_i = (op == OP_ADDI) || (op == OP_ORI);
        is_alu   = is_rtype || is_alu_i;
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_ls    = is_lw || is_sw;
        is_beq   = (op == OP_BEQ);
        is_j     = (op == OP_J);
        is_jr    = (op == OP_JR);
        is_jal   = (op == OP_JAL);
        is_jump  = is_j || is_jr || is_jal;
    end

    // State register, IF wait counter and sticky trap flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IF;
            wait_cnt <= 2'd0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op <= 1'b0;
`endif
        end else begin
            case (state)
                S_IF: begin
                    if (wait_cnt == IF_WAIT_C) begin
                        wait_cnt <= 2'd0;
                        state    <= S_ID;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_ID: begin
                    if (is_halt)       state <= S_HALT;
                    else if (is_jump)  state <= S_IF;
                    else if (is_beq)   state <= S_EXE_BR;
                    else if (is_ls)    state <= S_EXE_LS;
                    else if (is_alu)   state <= S_EXE_AL;
                    else begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state      <= S_HALT;
                        illegal_op <= 1'b1;
`else
                        state <= S_IF;
`endif
                    end
                end
                S_EXE_AL: state <= S_WB_AL;
                S_WB_AL:  state <= S_IF;
                S_EXE_BR: state <= S_IF;
                S_EXE_LS: state <= S_MEM;
                S_MEM:    state <= is_lw ? S_WB_LD : S_IF;
                S_WB_LD:  state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IF;
            endcase
        end
    end

`ifndef ILLEGAL_OP_TRAP_EN
    assign illegal_op = 1'b0;
`endif

    // Output decode. Static fields are only driven once op is valid (ID onwards),
    // so IF and HALT present a clean all-zero control word apart from the fetch strobes.
    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegData = 1'b0;
        DBDataSrc = 1'b0;
        DataMemRW = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        PCSrc     = 2'b00;
        ALUOp     = ALU_ADD;

        if (state != S_IF && state != S_HALT) begin
            if (is_rtype)                                      RegDst = 2'b10;
            else if ((op == OP_ADDI) || (op == OP_ORI) || is_lw) RegDst = 2'b01;
            ALUSrcB = is_alu_i || is_ls;
            ALUSrcA = (op == OP_SLL);
            ExtSel  = (op != OP_ORI);
            case (op)
                OP_SUB, OP_BEQ: ALUOp = ALU_SUB;
                OP_SLL:         ALUOp = ALU_SLL;
                OP_OR, OP_ORI:  ALUOp = ALU_OR;
                OP_AND:         ALUOp = ALU_AND;
                OP_SLT:         ALUOp = ALU_SLT;
                default:        ALUOp = ALU_ADD;
            endcase
        end

        case (state)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = (wait_cnt == IF_WAIT_C);
            end
            S_ID: begin
                if (!is_halt) begin
                    if (is_j || is_jal) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end else if (is_jr) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end
`ifndef ILLEGAL_OP_TRAP_EN
                    else if (!is_beq && !is_ls && !is_alu) begin
                        PCWre = 1'b1;   // undefined opcode falls through as a NOP
                    end
`endif
                    if (is_jal) begin
                        RegWre    = 1'b1;
                        RegDst    = 2'b00;
                        WrRegData = 1'b0;   // link value is PC+4
                    end
                end
            end
            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegData = 1'b1;
                PCWre     = 1'b1;
            end
            S_EXE_BR: begin
                PCWre = 1'b1;
                PCSrc = zero ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                if (is_sw) begin
                    DataMemRW = 1'b1;
                    PCWre     = 1'b1;
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                DBDataSrc = 1'b1;
                WrRegData = 1'b1;
                PCWre     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Purpose: directed self-checking bench for multicycle_ctrl_fsm (IF_WAIT=0 main DUT, IF_WAIT=2 side DUT).
// Latency: outputs compared once per cycle on the falling edge.
// Backpressure: not applicable.

module tb_multicycle_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [5:0] op  = 6'b000000;
    logic       zero = 1'b0;

    logic       PCWre, IRWre, InsMemRW, RegWre, WrRegData, DBDataSrc, DataMemRW;
    logic       ALUSrcA, ALUSrcB, ExtSel, illegal_op;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    logic       PCWre2, IRWre2, InsMemRW2, RegWre2, WrRegData2, DBDataSrc2, DataMemRW2;
    logic       ALUSrcA2, ALUSrcB2, ExtSel2, illegal_op2;
    logic [1:0] RegDst2, PCSrc2;
    logic [2:0] ALUOp2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    multicycle_ctrl_fsm #(.IF_WAIT(0)) dut (
        .CLK(CLK), .RST(RST), .op(op), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegData(WrRegData), .DBDataSrc(DBDataSrc),
        .DataMemRW(DataMemRW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .illegal_op(illegal_op)
    );

    multicycle_ctrl_fsm #(.IF_WAIT(2)) dut_w2 (
        .CLK(CLK), .RST(RST), .op(op), .zero(zero),
        .PCWre(PCWre2), .IRWre(IRWre2), .InsMemRW(InsMemRW2), .RegWre(RegWre2),
        .RegDst(RegDst2), .WrRegData(WrRegData2), .DBDataSrc(DBDataSrc2),
        .DataMemRW(DataMemRW2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2),
        .ExtSel(ExtSel2), .PCSrc(PCSrc2), .ALUOp(ALUOp2), .illegal_op(illegal_op2)
    );

    // Control word: {PCWre,IRWre,InsMemRW,RegWre,RegDst,WrRegData,DBDataSrc,DataMemRW,ALUSrcA,ALUSrcB,ExtSel,PCSrc,ALUOp}
    logic [16:0] obs, obs2;
    assign obs  = {PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegData, DBDataSrc, DataMemRW,
                   ALUSrcA, ALUSrcB, ExtSel, PCSrc, ALUOp};
    assign obs2 = {PCWre2, IRWre2, InsMemRW2, RegWre2, RegDst2, WrRegData2, DBDataSrc2, DataMemRW2,
                   ALUSrcA2, ALUSrcB2, ExtSel2, PCSrc2, ALUOp2};

    function automatic logic [16:0] ov(input logic pcw, input logic irw, input logic ins, input logic rw,
                                       input logic [1:0] rd, input logic wrd, input logic dbs,
                                       input logic dmw, input logic asa, input logic asb, input logic ext,
                                       input logic [1:0] pcs, input logic [2:0] aop);
        return {pcw, irw, ins, rw, rd, wrd, dbs, dmw, asa, asb, ext, pcs, aop};
    endfunction

    logic [16:0] IFV, ZERO_V, WB_BITS;

    // Reset pulse aligned to falling edges; returns on the falling edge that starts IF.
    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #2 RST = 1'b1;
        @(negedge CLK);
        checks++;
        if (obs !== IFV) begin
            errors++; $display("FAIL reset_word got %b exp %b", obs, IFV);
        end
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++; $display("FAIL reset_illegal got %b exp 0", illegal_op);
        end
        checks++;
        if (obs2 !== ov(0,0,1,0,2'b00,0,0,0,0,0,0,2'b00,3'b000)) begin
            errors++; $display("FAIL reset_word_w2 got %b exp IRWre=0 InsMemRW=1", obs2);
        end
        RST = 1'b0;
    endtask

    task automatic test_add();
        logic [16:0] e [5];
        do_reset();
        op = 6'b000000;
        e[0] = IFV;
        e[1] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b000);
        e[2] = e[1];
        e[3] = ov(1,0,0,1,2'b10,1,0,0,0,0,1,2'b00,3'b000);
        e[4] = IFV;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs !== e[c]) begin
                errors++; $display("FAIL add cyc%0d got %b exp %b", c, obs, e[c]);
            end
            if (c < 4) @(negedge CLK);
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0]  ops [7];
        logic [16:0] dec [7];
        ops[0] = 6'b000001; dec[0] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b001); // sub
        ops[1] = 6'b010000; dec[1] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b011); // or
        ops[2] = 6'b010001; dec[2] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b100); // and
        ops[3] = 6'b011000; dec[3] = ov(0,0,0,0,2'b10,0,0,0,1,0,1,2'b00,3'b010); // sll
        ops[4] = 6'b100110; dec[4] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b110); // slt
        ops[5] = 6'b000010; dec[5] = ov(0,0,0,0,2'b01,0,0,0,0,1,1,2'b00,3'b000); // addi
        ops[6] = 6'b010010; dec[6] = ov(0,0,0,0,2'b01,0,0,0,0,1,0,2'b00,3'b011); // ori
        for (int i = 0; i < 7; i++) begin
            op = ops[i];
            for (int c = 0; c < 4; c++) begin
                logic [16:0] ex;
                ex = (c == 0) ? IFV : (c == 3) ? (dec[i] | WB_BITS) : dec[i];
                checks++;
                if (obs !== ex) begin
                    errors++; $display("FAIL alu op%b cyc%0d got %b exp %b", ops[i], c, obs, ex);
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_lw_sw();
        logic [16:0] e [6];
        op = 6'b110001;
        e[0] = IFV;
        e[1] = ov(0,0,0,0,2'b01,0,0,0,0,1,1,2'b00,3'b000);
        e[2] = e[1];
        e[3] = e[1];
        e[4] = ov(1,0,0,1,2'b01,1,1,0,0,1,1,2'b00,3'b000);
        e[5] = IFV;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs !== e[c]) begin
                errors++; $display("FAIL lw cyc%0d got %b exp %b", c, obs, e[c]);
            end
            @(negedge CLK);
        end
        op = 6'b110000;
        e[1] = ov(0,0,0,0,2'b00,0,0,0,0,1,1,2'b00,3'b000);
        e[2] = e[1];
        e[3] = ov(1,0,0,0,2'b00,0,0,1,0,1,1,2'b00,3'b000);
        e[4] = IFV;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs !== e[c]) begin
                errors++; $display("FAIL sw cyc%0d got %b exp %b", c, obs, e[c]);
            end
            if (c < 4) @(negedge CLK);
        end
    endtask

    task automatic test_beq();
        logic [16:0] idv;
        idv = ov(0,0,0,0,2'b00,0,0,0,0,0,1,2'b00,3'b001);
        op = 6'b110100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            for (int c = 0; c < 4; c++) begin
                logic [16:0] ex;
                if (c == 1)      ex = idv;
                else if (c == 2) ex = ov(1,0,0,0,2'b00,0,0,0,0,0,1,(z == 1) ? 2'b01 : 2'b00,3'b001);
                else             ex = IFV;
                checks++;
                if (obs !== ex) begin
                    errors++; $display("FAIL beq z%0d cyc%0d got %b exp %b", z, c, obs, ex);
                end
                if (c < 3) @(negedge CLK);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jumps();
        logic [5:0]  ops [3];
        logic [16:0] idv [3];
        ops[0] = 6'b111010; idv[0] = ov(1,0,0,1,2'b00,0,0,0,0,0,1,2'b11,3'b000); // jal
        ops[1] = 6'b111000; idv[1] = ov(1,0,0,0,2'b00,0,0,0,0,0,1,2'b11,3'b000); // j
        ops[2] = 6'b111001; idv[2] = ov(1,0,0,0,2'b00,0,0,0,0,0,1,2'b10,3'b000); // jr
        for (int i = 0; i < 3; i++) begin
            op = ops[i];
            for (int c = 0; c < 3; c++) begin
                logic [16:0] ex;
                ex = (c == 1) ? idv[i] : IFV;
                checks++;
                if (obs !== ex) begin
                    errors++; $display("FAIL jump op%b cyc%0d got %b exp %b", ops[i], c, obs, ex);
                end
                if (c < 2) @(negedge CLK);
            end
        end
    endtask

    task automatic test_halt();
        op = 6'b111111;
        checks++;
        if (obs !== IFV) begin
            errors++; $display("FAIL halt_if got %b exp %b", obs, IFV);
        end
        @(negedge CLK);
        checks++;
        if (obs !== ov(0,0,0,0,2'b00,0,0,0,0,0,1,2'b00,3'b000)) begin
            errors++; $display("FAIL halt_id got %b", obs);
        end
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs !== ZERO_V) begin
                errors++; $display("FAIL halt_hold cyc%0d got %b exp %b", c, obs, ZERO_V);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [16:0] idadd;
        idadd = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b000);
        do_reset();
        op = 6'b110000;
        @(negedge CLK);             // ID
        @(negedge CLK);             // EXE_LS
        checks++;
        if (obs !== ov(0,0,0,0,2'b00,0,0,0,0,1,1,2'b00,3'b000)) begin
            errors++; $display("FAIL rstmid_exe got %b", obs);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (obs !== IFV) begin
            errors++; $display("FAIL rstmid_async got %b exp %b", obs, IFV);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            checks++;
            if (DataMemRW !== 1'b0 || obs !== IFV) begin
                errors++; $display("FAIL rstmid_hold cyc%0d got %b exp %b", c, obs, IFV);
            end
        end
        RST = 1'b0;
        op = 6'b000000;
        for (int c = 0; c < 3; c++) begin
            logic [16:0] ex;
            ex = (c == 0) ? IFV : idadd;
            checks++;
            if (obs !== ex) begin
                errors++; $display("FAIL rstmid_resume cyc%0d got %b exp %b", c, obs, ex);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_if_wait();
        logic [16:0] e [4];
        do_reset();
        op = 6'b000000;
        e[0] = ov(0,0,1,0,2'b00,0,0,0,0,0,0,2'b00,3'b000);
        e[1] = e[0];
        e[2] = IFV;
        e[3] = ov(0,0,0,0,2'b10,0,0,0,0,0,1,2'b00,3'b000);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs2 !== e[c]) begin
                errors++; $display("FAIL ifwait2 cyc%0d got %b exp %b", c, obs2, e[c]);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_illegal();
        logic [16:0] idv, after;
        logic        ill_after;
`ifdef ILLEGAL_OP_TRAP_EN
        idv       = ov(0,0,0,0,2'b00,0,0,0,0,0,1,2'b00,3'b000);
        after     = ZERO_V;
        ill_after = 1'b1;
`else
        idv       = ov(1,0,0,0,2'b00,0,0,0,0,0,1,2'b00,3'b000);
        after     = IFV;
        ill_after = 1'b0;
`endif
        do_reset();
        op = 6'b101010;
        @(negedge CLK);
        checks++;
        if (obs !== idv || illegal_op !== 1'b0) begin
            errors++; $display("FAIL illegal_id got %b ill=%b exp %b ill=0", obs, illegal_op, idv);
        end
        @(negedge CLK);
        checks++;
        if (obs !== after || illegal_op !== ill_after) begin
            errors++; $display("FAIL illegal_next got %b ill=%b exp %b ill=%b", obs, illegal_op, after, ill_after);
        end
        do_reset();
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++; $display("FAIL illegal_clear got %b exp 0", illegal_op);
        end
    endtask

    initial begin
        IFV     = ov(0,1,1,0,2'b00,0,0,0,0,0,0,2'b00,3'b000);
        ZERO_V  = '0;
        WB_BITS = ov(1,0,0,1,2'b00,1,0,0,0,0,0,2'b00,3'b000);
        test_reset();
        test_add();
        test_alu_ops();
        test_lw_sw();
        test_beq();
        test_jumps();
        test_halt();
        test_reset_mid_sw();
        test_if_wait();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
